// File: rtl/sram_1rw_1024x36_ctrl.sv
// ----------------------------------------------------------------------------
// sram_1rw_1024x36_ctrl
//
// Initiator-side controller for a single-port 1024x36 SRAM macro. It merges
// independent write and read request streams onto the single RW port with
// round-robin arbitration. Read data comes back from the macro one cycle after
// the read. That data is captured into a small response FIFO. A read is only
// accepted when the FIFO is sure to have room for it, so the FIFO never
// overflows.
//
// Ports
//   clock, reset_n           single clock, asynchronous active-low reset
//   wr_valid/wr_ready        write request handshake (wr_addr, wr_data)
//   rd_valid/rd_ready        read request handshake (rd_addr)
//   rsp_valid/rsp_ready      read response handshake (rsp_data, request order)
//   sram_addr/en/wmode/wdata drive the macro RW0 port (wmode 1 = write)
//   sram_rdata               macro RW0 read data, meaningful one cycle after a read
// ----------------------------------------------------------------------------
module sram_1rw_1024x36_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 36,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,

    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    // Which side won the most recent fire; used to alternate under contention.
    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

    grant_e            last_grant;
    grant_e            last_grant_next;
    logic              rd_pending;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

    logic              wr_fire;
    logic              rd_fire;
    logic              push;
    logic              pop;
    logic              full;
    logic              rd_ok;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Credit: entries held plus the read whose data lands this cycle,
    // minus the entry leaving this cycle. A new read is taken only if
    // that still leaves a free slot for its data two cycles from now.
    // pop implies count >= 1, so the subtraction cannot underflow.
    // ------------------------------------------------------------------
    assign push        = rd_pending;
    assign rsp_valid   = (count != '0);
    assign pop         = rsp_valid & rsp_ready;
    assign full        = (count == CNT_W'(RESP_DEPTH));
    assign credit_used = {1'b0, count} + (CNT_W + 1)'(rd_pending) - (CNT_W + 1)'(pop);
    assign rd_ok       = (credit_used < (CNT_W + 1)'(RESP_DEPTH));

    // ------------------------------------------------------------------
    // Arbitration and grant tracking.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        wr_ready        = 1'b0;
        rd_ready        = 1'b0;
        last_grant_next = last_grant;

        if (wr_valid && rd_valid) begin
            // Read wins only if it has credit and write won last time.
            if (rd_ok && (last_grant == GRANT_WR)) begin
                rd_ready = 1'b1;
            end else begin
                wr_ready = 1'b1;
            end
        end else if (wr_valid) begin
            wr_ready = 1'b1;
        end else if (rd_valid) begin
            rd_ready = rd_ok;
        end

        if (wr_valid && wr_ready) begin
            last_grant_next = GRANT_WR;
        end else if (rd_valid && rd_ready) begin
            last_grant_next = GRANT_RD;
        end
    end

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    // ------------------------------------------------------------------
    // Macro port: idle cycles drive zeros so the macro inputs stay quiet.
    // ------------------------------------------------------------------
    assign sram_en    = wr_fire | rd_fire;
    assign sram_wmode = wr_fire;
    assign sram_addr  = wr_fire ? wr_addr : (rd_fire ? rd_addr : '0);
    assign sram_wdata = wr_fire ? wr_data : '0;

    // The head entry is masked when empty, so reset gives rsp_data = 0
    // without needing to clear the storage.
    assign rsp_data = rsp_valid ? fifo_mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Control state.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GRANT_RD;
            rd_pending <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge, whatever the
            // statement order.
            last_grant <= last_grant_next;
            rd_pending <= rd_fire;

            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the FIFO storage is deliberately left out of reset; count and
    // the pointers decide what is valid, and the read side masks stale words.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_rdata;
        end
    end

    // The credit check above guarantees a full FIFO is never pushed
    // without a simultaneous pop.
    no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
                                  !(push && full && !pop));

endmodule

// File: tb/tb_sram_1rw_1024x36_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw_1024x36_ctrl
//
// Directed bench for sram_1rw_1024x36_ctrl. A behavioural 1024x36 macro model
// stores writes and returns read data one cycle after the read. On cycles
// without a read it returns a poison word. Inputs are driven 1 time unit after
// the rising edge. Outputs are compared 1 time unit later, well before the
// next edge.
// ----------------------------------------------------------------------------
module tb_sram_1rw_1024x36_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 36;
    localparam logic [DATA_W-1:0] POISON = 36'hB_ADBA_DBAD;

    logic              clock;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int checks;
    int failures;

    sram_1rw_1024x36_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RESP_DEPTH (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: a write updates memory at the edge. Read data appears
    // after the edge that samples the read.
    logic [DATA_W-1:0] macro_mem [1024];
    always @(posedge clock) begin
        if (sram_en && sram_wmode) begin
            macro_mem[sram_addr] <= sram_wdata;
            sram_rdata           <= POISON;
        end else if (sram_en) begin
            sram_rdata <= macro_mem[sram_addr];
        end else begin
            sram_rdata <= POISON;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int issued;
        int got;
        logic fire;

        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_wmode", sram_wmode, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_wr_ready_idle", wr_ready, 0);
        check("rst_rd_ready_idle", rd_ready, 0);
        wr_valid = 1'b1;
        #1;
        check("rst_wr_ready_valid", wr_ready, 1);
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        #1;
        check("rst_rd_ready_valid", rd_ready, 1);
        rd_valid = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // ---------------- write then read ----------------
        wr_valid = 1'b1;
        wr_addr  = 10'h005;
        wr_data  = 36'h9_ABCD_1234;
        #1;
        check("w_wr_ready", wr_ready, 1);
        check("w_sram_en", sram_en, 1);
        check("w_sram_wmode", sram_wmode, 1);
        check("w_sram_addr", sram_addr, 10'h005);
        check("w_sram_wdata", sram_wdata, 36'h9_ABCD_1234);
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 10'h005;
        #1;
        check("r_rd_ready", rd_ready, 1);
        check("r_sram_en", sram_en, 1);
        check("r_sram_wmode", sram_wmode, 0);
        check("r_sram_addr", sram_addr, 10'h005);
        check("r_sram_wdata", sram_wdata, 0);
        cyc();
        rd_valid = 1'b0;
        #1;
        check("r_t1_rsp_valid", rsp_valid, 0);
        check("r_t1_sram_en", sram_en, 0);
        cyc();
        #1;
        check("r_t2_rsp_valid", rsp_valid, 1);
        check("r_t2_rsp_data", rsp_data, 36'h9_ABCD_1234);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        check("r_popped_empty", rsp_valid, 0);

        // ---------------- prefill 0x000..0x00F with data = addr ----------------
        for (int i = 0; i < 16; i++) begin
            cyc();
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(i);
            wr_data  = DATA_W'(i);
        end
        cyc();
        wr_valid = 1'b0;

        // ---------------- streaming reads ----------------
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            rd_valid = (c < 16);
            rd_addr  = ADDR_W'(c);
            #1;
            if (c < 16) check("stream_rd_ready", rd_ready, 1);
            check("stream_rsp_valid", rsp_valid, (c >= 2 && c < 18));
            if (rsp_valid) begin
                check("stream_rsp_data", rsp_data, n);
                n++;
            end
            cyc();
        end
        check("stream_count", n, 16);

        // ---------------- backpressure ----------------
        issued = 0;
        got    = 0;
        for (int c = 0; c < 20; c++) begin
            rsp_ready = (c >= 5);
            rd_valid  = (issued < 4);
            rd_addr   = ADDR_W'(3 + issued);
            #1;
            if (c < 5) check("bp_rd_ready", rd_ready, (c < 2));
            if (c >= 2 && c < 5) begin
                check("bp_issued_stall", issued, 2);
                check("bp_hold_valid", rsp_valid, 1);
                check("bp_hold_data", rsp_data, 3);
            end
            fire = rd_valid & rd_ready;
            if (rsp_valid && rsp_ready) begin
                check("bp_rsp_data", rsp_data, 3 + got);
                got++;
            end
            cyc();
            if (fire) issued++;
        end
        rd_valid = 1'b0;
        check("bp_issued_total", issued, 4);
        check("bp_rsp_total", got, 4);

        // ---------------- contention with credit: W,R,W,R,W,R ----------------
        got = 0;
        for (int c = 0; c < 10; c++) begin
            rsp_ready = 1'b1;
            wr_valid  = (c < 6);
            rd_valid  = (c < 6);
            wr_addr   = ADDR_W'(32 + ((c + 1) / 2) * 2);
            rd_addr   = ADDR_W'(32 + (c / 2) * 2);
            wr_data   = 36'hA_0000_0000 | DATA_W'(wr_addr);
            #1;
            if (c < 6) begin
                check("cont_wr_ready", wr_ready, (c % 2) == 0);
                check("cont_rd_ready", rd_ready, (c % 2) == 1);
                check("cont_sram_wmode", sram_wmode, (c % 2) == 0);
            end
            if (rsp_valid) begin
                check("cont_rsp_data", rsp_data, 36'hA_0000_0020 + 2 * got);
                got++;
            end
            cyc();
        end
        check("cont_rsp_total", got, 3);

        // ---------------- contention with FIFO full: W every cycle ----------------
        rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rd_valid = 1'b1;
            rd_addr  = ADDR_W'(c);
            #1;
            check("full_fill_rd_ready", rd_ready, 1);
            cyc();
        end
        for (int c = 2; c < 6; c++) begin
            wr_valid = 1'b1;
            rd_valid = 1'b1;
            rd_addr  = 10'h002;
            wr_addr  = ADDR_W'(48 + c);
            wr_data  = DATA_W'(c);
            #1;
            check("full_wr_ready", wr_ready, 1);
            check("full_rd_ready", rd_ready, 0);
            cyc();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;

        // ---------------- push and pop in the same cycle from full ----------------
        issued = 0;
        n      = 0;
        for (int c = 0; c < 8; c++) begin
            rsp_ready = 1'b1;
            rd_valid  = (issued < 4);
            rd_addr   = ADDR_W'(2 + issued);
            #1;
            if (c < 4) check("pp_rd_ready", rd_ready, 1);
            if (c < 6) check("pp_rsp_valid", rsp_valid, 1);
            fire = rd_valid & rd_ready;
            if (rsp_valid && rsp_ready) begin
                check("pp_rsp_data", rsp_data, n);
                n++;
            end
            cyc();
            if (fire) issued++;
        end
        rd_valid = 1'b0;
        check("pp_rsp_total", n, 6);

        // ---------------- reset mid-read ----------------
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 10'h006;
        cyc();
        rd_addr   = 10'h007;
        cyc();
        rd_valid  = 1'b0;
        #1;
        check("mr_pre_rsp_valid", rsp_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_data", rsp_data, 0);
        check("mr_sram_en", sram_en, 0);
        check("mr_sram_wmode", sram_wmode, 0);
        cyc();
        cyc();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("mr_no_stale_rsp", rsp_valid, 0);
            cyc();
        end
        rd_valid = 1'b1;
        rd_addr  = 10'h009;
        rsp_ready = 1'b0;
        #1;
        check("mr_next_rd_ready", rd_ready, 1);
        cyc();
        rd_valid = 1'b0;
        cyc();
        #1;
        check("mr_next_rsp_valid", rsp_valid, 1);
        check("mr_next_rsp_data", rsp_data, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
